axi_rd_interconnect_nxm: RTL and testbench

Parametrised N-master × M-slave AXI read-channel interconnect (AR + R only), successor to the fixed 2×2 read interconnect. Adds run-time address map vectors, per-slave round-robin arbitration, a registered slave-side AR stage, burst tracking with per-slave lock until RLAST, and an internal DECERR responder for unmapped addresses. Sits between read masters (DMA/CPU ports) and memory-mapped read slaves in the system fabric.

---
 rtl/axi_rd_interconnect_nxm.sv | 190 +++++++++++++++++++
 tb/tb_axi_rd_interconnect_nxm.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_interconnect_nxm.sv
// N-master x M-slave AXI read interconnect (AR + R channels only).
// Per-target round-robin arbitration, registered slave AR stage, burst lock until RLAST, internal DECERR responder.
module axi_rd_interconnect_nxm #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 4,
  parameter int SIZE_W      = 3,
  parameter int DATA_W      = 32
) (
  input  logic                             G_clk,
  input  logic                             G_reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0]    M_ARADDR,
  input  logic [NUM_MASTERS*LEN_W-1:0]     M_ARLEN,
  input  logic [NUM_MASTERS*SIZE_W-1:0]    M_ARSIZE,
  input  logic [NUM_MASTERS*2-1:0]         M_ARBURST,
  input  logic [NUM_MASTERS-1:0]           M_ARVALID,
  input  logic [NUM_MASTERS-1:0]           M_RREADY,
  output logic [NUM_MASTERS-1:0]           M_ARREADY,
  output logic [NUM_MASTERS-1:0]           M_RVALID,
  output logic [NUM_MASTERS-1:0]           M_RLAST,
  output logic [NUM_MASTERS*2-1:0]         M_RRESP,
  output logic [NUM_MASTERS*DATA_W-1:0]    M_RDATA,
  output logic [NUM_SLAVES*ADDR_W-1:0]     S_ARADDR,
  output logic [NUM_SLAVES*LEN_W-1:0]      S_ARLEN,
  output logic [NUM_SLAVES*SIZE_W-1:0]     S_ARSIZE,
  output logic [NUM_SLAVES*2-1:0]          S_ARBURST,
  output logic [NUM_SLAVES-1:0]            S_ARVALID,
  output logic [NUM_SLAVES-1:0]            S_RREADY,
  input  logic [NUM_SLAVES-1:0]            S_ARREADY,
  input  logic [NUM_SLAVES-1:0]            S_RVALID,
  input  logic [NUM_SLAVES-1:0]            S_RLAST,
  input  logic [NUM_SLAVES*2-1:0]          S_RRESP,
  input  logic [NUM_SLAVES*DATA_W-1:0]     S_RDATA,
  input  logic [NUM_SLAVES*ADDR_W-1:0]     SLAVE_ADDR_LO,
  input  logic [NUM_SLAVES*ADDR_W-1:0]     SLAVE_ADDR_HI
);

  localparam int NT  = NUM_SLAVES + 1;
  localparam int DEC = NUM_SLAVES;
  localparam int TW  = $clog2(NT);
  localparam int MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t             r_state     [NT];
  state_t             w_state_nxt [NT];
  logic [MW-1:0]      r_owner     [NT];
  logic [MW-1:0]      r_rr_ptr    [NT];
  logic [ADDR_W-1:0]  r_addr      [NT];
  logic [LEN_W-1:0]   r_len       [NT];
  logic [SIZE_W-1:0]  r_size      [NT];
  logic [1:0]         r_burst     [NT];
  logic [LEN_W-1:0]   r_dec_cnt;
  logic [NUM_MASTERS-1:0] r_busy;

  logic [TW-1:0]      w_tgt       [NUM_MASTERS];
  logic               w_grant     [NT];
  logic [MW-1:0]      w_win       [NT];
  logic               w_done      [NT];
  logic [MW-1:0]      w_cand;

  // Address decode: lowest matching window wins, no match selects the DECERR target.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_tgt[i] = TW'(NUM_SLAVES);
      for (int j = NUM_SLAVES - 1; j >= 0; j--) begin
        if (M_ARADDR[i*ADDR_W +: ADDR_W] >= SLAVE_ADDR_LO[j*ADDR_W +: ADDR_W] &&
            M_ARADDR[i*ADDR_W +: ADDR_W] <= SLAVE_ADDR_HI[j*ADDR_W +: ADDR_W])
          w_tgt[i] = TW'(j);
      end
    end
  end

  // Round-robin search starting at rr_ptr; grants are suppressed while reset is asserted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_cand = '0;
    for (int j = 0; j < NT; j++) begin
      w_grant[j] = 1'b0;
      w_win[j]   = '0;
      if (G_reset && r_state[j] == ST_IDLE) begin
        for (int k = 0; k < NUM_MASTERS; k++) begin
          w_cand = MW'((int'(r_rr_ptr[j]) + k) % NUM_MASTERS);
          if (!w_grant[j] && M_ARVALID[w_cand] && !r_busy[w_cand] && w_tgt[w_cand] == TW'(j)) begin
            w_grant[j] = 1'b1;
            w_win[j]   = w_cand;
          end
        end
      end
    end
  end

  always_comb begin
    M_ARREADY = '0;
    M_RVALID  = '0;
    M_RLAST   = '0;
    M_RRESP   = '0;
    M_RDATA   = '0;
    S_ARADDR  = '0;
    S_ARLEN   = '0;
    S_ARSIZE  = '0;
    S_ARBURST = '0;
    S_ARVALID = '0;
    S_RREADY  = '0;
    for (int j = 0; j < NT; j++) begin
      w_state_nxt[j] = r_state[j];
      w_done[j]      = 1'b0;
      if (w_grant[j]) M_ARREADY[w_win[j]] = 1'b1;
    end

    for (int j = 0; j < NUM_SLAVES; j++) begin
      case (r_state[j])
        ST_IDLE: if (w_grant[j]) w_state_nxt[j] = ST_ADDR;
        ST_ADDR: begin
          S_ARVALID[j]                  = 1'b1;
          S_ARADDR[j*ADDR_W +: ADDR_W]  = r_addr[j];
          S_ARLEN[j*LEN_W +: LEN_W]     = r_len[j];
          S_ARSIZE[j*SIZE_W +: SIZE_W]  = r_size[j];
          S_ARBURST[j*2 +: 2]           = r_burst[j];
          if (S_ARREADY[j]) w_state_nxt[j] = ST_DATA;
        end
        ST_DATA: begin
          M_RVALID[r_owner[j]]                  = S_RVALID[j];
          M_RLAST[r_owner[j]]                   = S_RLAST[j];
          M_RRESP[r_owner[j]*2 +: 2]            = S_RRESP[j*2 +: 2];
          M_RDATA[r_owner[j]*DATA_W +: DATA_W]  = S_RDATA[j*DATA_W +: DATA_W];
          S_RREADY[j]                           = M_RREADY[r_owner[j]];
          if (S_RVALID[j] && M_RREADY[r_owner[j]] && S_RLAST[j]) begin
            w_done[j]      = 1'b1;
            w_state_nxt[j] = ST_IDLE;
          end
        end
        default: w_state_nxt[j] = ST_IDLE;
      endcase
    end

    // DECERR target has no AR stage and answers every beat itself.
    case (r_state[DEC])
      ST_IDLE: if (w_grant[DEC]) w_state_nxt[DEC] = ST_DATA;
      ST_DATA: begin
        M_RVALID[r_owner[DEC]]       = 1'b1;
        M_RRESP[r_owner[DEC]*2 +: 2] = 2'b11;
        M_RLAST[r_owner[DEC]]        = (r_dec_cnt == r_len[DEC]);
        if (M_RREADY[r_owner[DEC]] && r_dec_cnt == r_len[DEC]) begin
          w_done[DEC]      = 1'b1;
          w_state_nxt[DEC] = ST_IDLE;
        end
      end
      default: w_state_nxt[DEC] = ST_IDLE;
    endcase
  end

  always_ff @(posedge G_clk or negedge G_reset) begin
    if (!G_reset) begin
      // NOTE: these per-target arrays are small control registers, not a RAM, so resetting them is fine.
      for (int j = 0; j < NT; j++) begin
        r_state[j]  <= ST_IDLE;
        r_owner[j]  <= '0;
        r_rr_ptr[j] <= '0;
        r_addr[j]   <= '0;
        r_len[j]    <= '0;
        r_size[j]   <= '0;
        r_burst[j]  <= '0;
      end
      r_dec_cnt <= '0;
      r_busy    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      for (int j = 0; j < NT; j++) begin
        r_state[j] <= w_state_nxt[j];
        if (w_done[j]) r_busy[r_owner[j]] <= 1'b0;
        if (w_grant[j]) begin
          r_owner[j]          <= w_win[j];
          r_rr_ptr[j]         <= MW'((int'(w_win[j]) + 1) % NUM_MASTERS);
          r_addr[j]           <= M_ARADDR[w_win[j]*ADDR_W +: ADDR_W];
          r_len[j]            <= M_ARLEN[w_win[j]*LEN_W +: LEN_W];
          r_size[j]           <= M_ARSIZE[w_win[j]*SIZE_W +: SIZE_W];
          r_burst[j]          <= M_ARBURST[w_win[j]*2 +: 2];
          r_busy[w_win[j]]    <= 1'b1;
        end
      end
      if (w_grant[DEC])
        r_dec_cnt <= '0;
      else if (r_state[DEC] == ST_DATA && M_RREADY[r_owner[DEC]])
        r_dec_cnt <= r_dec_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_interconnect_nxm.sv
// Directed bench for axi_rd_interconnect_nxm (2 masters, 2 slaves) with a behavioural slave model.
// Slave s returns data {s, addr + beat} so routing and address pass-through are both visible.
module tb_axi_rd_interconnect_nxm;

  localparam int NM = 2;
  localparam int NS = 2;

  logic              G_clk;
  logic              G_reset;
  logic [NM*32-1:0]  M_ARADDR;
  logic [NM*4-1:0]   M_ARLEN;
  logic [NM*3-1:0]   M_ARSIZE;
  logic [NM*2-1:0]   M_ARBURST;
  logic [NM-1:0]     M_ARVALID, M_RREADY;
  logic [NM-1:0]     M_ARREADY, M_RVALID, M_RLAST;
  logic [NM*2-1:0]   M_RRESP;
  logic [NM*32-1:0]  M_RDATA;
  logic [NS*32-1:0]  S_ARADDR;
  logic [NS*4-1:0]   S_ARLEN;
  logic [NS*3-1:0]   S_ARSIZE;
  logic [NS*2-1:0]   S_ARBURST;
  logic [NS-1:0]     S_ARVALID, S_RREADY;
  logic [NS-1:0]     S_ARREADY, S_RVALID, S_RLAST;
  logic [NS*2-1:0]   S_RRESP;
  logic [NS*32-1:0]  S_RDATA;
  logic [NS*32-1:0]  SLAVE_ADDR_LO, SLAVE_ADDR_HI;

  logic [NS-1:0]     ar_block;
  int                n_checks;
  int                n_fail;

  axi_rd_interconnect_nxm #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(32), .LEN_W(4), .SIZE_W(3), .DATA_W(32)
  ) dut (
    .G_clk(G_clk), .G_reset(G_reset),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_ARVALID(M_ARVALID), .M_RREADY(M_RREADY),
    .M_ARREADY(M_ARREADY), .M_RVALID(M_RVALID), .M_RLAST(M_RLAST), .M_RRESP(M_RRESP), .M_RDATA(M_RDATA),
    .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_ARVALID(S_ARVALID), .S_RREADY(S_RREADY),
    .S_ARREADY(S_ARREADY), .S_RVALID(S_RVALID), .S_RLAST(S_RLAST), .S_RRESP(S_RRESP), .S_RDATA(S_RDATA),
    .SLAVE_ADDR_LO(SLAVE_ADDR_LO), .SLAVE_ADDR_HI(SLAVE_ADDR_HI)
  );

  initial G_clk = 1'b0;
  always #5 G_clk = ~G_clk;

  function automatic logic [31:0] exp_data(input int s, input logic [31:0] addr, input int beat);
    return (32'(s) << 28) | (addr + 32'(beat));
  endfunction

  function automatic logic any_out();
    return |{M_ARREADY, M_RVALID, M_RLAST, M_RRESP, M_RDATA, S_ARADDR, S_ARLEN,
             S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural slaves: accept one AR when idle, then stream len+1 beats.
  initial begin : slave_model
    logic [31:0] s_addr [NS];
    logic [3:0]  s_len  [NS];
    logic [3:0]  s_beat [NS];
    bit          s_act  [NS];
    bit          arf    [NS];
    bit          rf     [NS];
    logic [31:0] a_addr [NS];
    logic [3:0]  a_len  [NS];
    S_ARREADY = '0; S_RVALID = '0; S_RLAST = '0; S_RRESP = '0; S_RDATA = '0;
    for (int s = 0; s < NS; s++) begin
      s_act[s] = 0; s_beat[s] = '0; s_len[s] = '0; s_addr[s] = '0;
    end
    forever begin
      @(negedge G_clk);
      for (int s = 0; s < NS; s++) begin
        arf[s]    = S_ARVALID[s] && S_ARREADY[s];
        rf[s]     = S_RVALID[s] && S_RREADY[s];
        a_addr[s] = S_ARADDR[s*32 +: 32];
        a_len[s]  = S_ARLEN[s*4 +: 4];
      end
      @(posedge G_clk); #1;
      for (int s = 0; s < NS; s++) begin
        if (!G_reset) begin
          s_act[s]           = 0;
          S_ARREADY[s]       = 1'($urandom);
          S_RVALID[s]        = 1'($urandom);
          S_RLAST[s]         = 1'($urandom);
          S_RRESP[s*2 +: 2]  = 2'($urandom);
          S_RDATA[s*32 +: 32] = $urandom;
        end else begin
          if (rf[s]) begin
            if (s_beat[s] == s_len[s]) s_act[s] = 0;
            else s_beat[s] = s_beat[s] + 4'd1;
          end
          if (arf[s]) begin
            s_act[s] = 1; s_addr[s] = a_addr[s]; s_len[s] = a_len[s]; s_beat[s] = '0;
          end
          S_ARREADY[s]        = !s_act[s] && !ar_block[s];
          S_RVALID[s]         = s_act[s];
          S_RLAST[s]          = s_act[s] && (s_beat[s] == s_len[s]);
          S_RRESP[s*2 +: 2]   = 2'b00;
          S_RDATA[s*32 +: 32] = s_act[s] ? exp_data(s, s_addr[s], int'(s_beat[s])) : 32'h0;
        end
      end
    end
  end

  // Single read from master m; slv == NS means the unmapped (DECERR) path.
  task automatic do_read(input int m, input logic [31:0] addr, input logic [3:0] len,
                         input int slv, input bit toggle, input string tag);
    int o, beat, cyc;
    bit got;
    logic [31:0] exp_d;
    o = 1 - m;
    @(posedge G_clk); #1;
    M_ARADDR[m*32 +: 32] = addr;
    M_ARLEN[m*4 +: 4]    = len;
    M_ARSIZE[m*3 +: 3]   = 3'd2;
    M_ARBURST[m*2 +: 2]  = 2'b01;
    M_ARVALID[m]         = 1'b1;
    M_RREADY[m]          = 1'b1;
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge G_clk);
      if (M_ARREADY[m]) got = 1;
      else begin @(posedge G_clk); #1; end
    end
    check({tag, "_grant"}, 64'(got), 64'd1);
    @(posedge G_clk); #1;
    M_ARVALID[m] = 1'b0;
    @(negedge G_clk);
    if (slv < NS) begin
      check({tag, "_sarvalid"}, 64'(S_ARVALID), 64'(1) << slv);
      check({tag, "_saraddr"}, 64'(S_ARADDR[slv*32 +: 32]), 64'(addr));
      check({tag, "_sarlen"}, 64'(S_ARLEN[slv*4 +: 4]), 64'(len));
    end else begin
      check({tag, "_no_sarvalid"}, 64'(S_ARVALID), 64'd0);
      check({tag, "_first_beat"}, 64'(M_RVALID[m]), 64'd1);
    end
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 40) begin
      if (M_RVALID[m]) begin
        exp_d = (slv < NS) ? exp_data(slv, addr, beat) : 32'h0;
        check($sformatf("%s_data%0d", tag, beat), 64'(M_RDATA[m*32 +: 32]), 64'(exp_d));
        check($sformatf("%s_resp%0d", tag, beat), 64'(M_RRESP[m*2 +: 2]), (slv < NS) ? 64'd0 : 64'd3);
        check($sformatf("%s_last%0d", tag, beat), 64'(M_RLAST[m]), 64'(beat == int'(len)));
        if (M_RREADY[m]) beat++;
      end
      check({tag, "_other_quiet"}, 64'({M_RVALID[o], M_RLAST[o], M_RDATA[o*32 +: 32]}), 64'd0);
      if (slv == NS) check({tag, "_dec_no_sar"}, 64'(S_ARVALID), 64'd0);
      @(posedge G_clk); #1; cyc++;
      if (toggle) M_RREADY[m] = ~M_RREADY[m];
      @(negedge G_clk);
    end
    check({tag, "_beats"}, 64'(beat), 64'(int'(len) + 1));
    check({tag, "_rvalid_done"}, 64'(M_RVALID[m]), 64'd0);
    M_RREADY[m] = 1'b1;
  endtask

  initial begin : main
    int gi, n0, n1, cyc, b0, b1;
    bit overlap, got;
    n_checks = 0; n_fail = 0;
    G_reset = 1'b0;
    ar_block = '0;
    M_ARADDR = '0; M_ARLEN = '0; M_ARSIZE = '0; M_ARBURST = '0; M_ARVALID = '0; M_RREADY = '0;
    SLAVE_ADDR_LO = {32'h0001_0000, 32'h0000_0000};
    SLAVE_ADDR_HI = {32'h0001_FFFF, 32'h0000_FFFF};

    // Reset with random master/slave activity: everything stays 0.
    for (int c = 0; c < 5; c++) begin
      @(posedge G_clk); #1;
      M_ARADDR = {$urandom, $urandom}; M_ARLEN = 8'($urandom); M_ARSIZE = 6'($urandom);
      M_ARBURST = 4'($urandom); M_ARVALID = 2'($urandom) | 2'b01; M_RREADY = 2'($urandom);
      @(negedge G_clk);
      check($sformatf("reset_outs%0d", c), 64'(any_out()), 64'd0);
    end
    @(posedge G_clk); #1;
    M_ARADDR = '0; M_ARLEN = '0; M_ARSIZE = '0; M_ARBURST = '0; M_ARVALID = '0; M_RREADY = '0;
    G_reset = 1'b1;

    do_read(0, 32'h0000_0010, 4'd0, 0, 0, "single");
    do_read(1, 32'h0001_0004, 4'd3, 1, 0, "burst");

    // Arbitration: fresh reset so both rr pointers start at M0.
    @(posedge G_clk); #1; G_reset = 1'b0;
    @(posedge G_clk); #1; G_reset = 1'b1;
    @(posedge G_clk); #1;
    M_ARADDR = {32'h0000_0200, 32'h0000_0100}; M_ARLEN = '0;
    M_ARVALID = 2'b11; M_RREADY = 2'b11;
    gi = 0; n0 = 0; n1 = 0; cyc = 0;
    while (gi < 8 && cyc < 200) begin
      @(negedge G_clk);
      if (M_ARREADY != '0) begin
        check($sformatf("arb_grant%0d", gi), 64'(M_ARREADY), 64'(1) << (gi % 2));
        if (M_ARREADY[0]) n0++; else n1++;
        gi++;
      end
      if (M_RVALID[0]) check("arb_data_m0", 64'(M_RDATA[31:0]), 64'h100);
      if (M_RVALID[1]) check("arb_data_m1", 64'(M_RDATA[63:32]), 64'h200);
      @(posedge G_clk); #1; cyc++;
      if (n0 >= 4) M_ARVALID[0] = 1'b0;
      if (n1 >= 4) M_ARVALID[1] = 1'b0;
    end
    check("arb_count", 64'(gi), 64'd8);
    repeat (4) @(posedge G_clk);

    // Parallel bursts to different slaves.
    @(posedge G_clk); #1;
    M_ARADDR = {32'h0001_0400, 32'h0000_0300}; M_ARLEN = {4'd3, 4'd3};
    M_ARVALID = 2'b11; M_RREADY = 2'b11;
    @(negedge G_clk);
    check("par_arready", 64'(M_ARREADY), 64'd3);
    @(posedge G_clk); #1; M_ARVALID = '0;
    @(negedge G_clk);
    check("par_sarvalid", 64'(S_ARVALID), 64'd3);
    b0 = 0; b1 = 0; cyc = 0; overlap = 0;
    while ((b0 < 4 || b1 < 4) && cyc < 40) begin
      @(negedge G_clk);
      if (M_RVALID[0] && M_RVALID[1]) overlap = 1;
      if (M_RVALID[0]) begin
        check($sformatf("par_m0_data%0d", b0), 64'(M_RDATA[31:0]), 64'(exp_data(0, 32'h300, b0)));
        b0++;
      end
      if (M_RVALID[1]) begin
        check($sformatf("par_m1_data%0d", b1), 64'(M_RDATA[63:32]), 64'(exp_data(1, 32'h0001_0400, b1)));
        b1++;
      end
      @(posedge G_clk); #1; cyc++;
    end
    check("par_beats", 64'({b0[7:0], b1[7:0]}), 64'h0404);
    check("par_overlap", 64'(overlap), 64'd1);

    // Unmapped address, RREADY toggling every cycle.
    do_read(0, 32'h0002_0000, 4'd2, NS, 1, "decerr");

    // AR backpressure, R stall, then reset mid-burst.
    @(posedge G_clk); #1;
    ar_block[0] = 1'b1;
    M_ARADDR[31:0] = 32'h0000_0040; M_ARLEN[3:0] = 4'd3; M_ARVALID[0] = 1'b1; M_RREADY[0] = 1'b1;
    @(negedge G_clk);
    check("bp_grant", 64'(M_ARREADY[0]), 64'd1);
    @(posedge G_clk); #1; M_ARVALID[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge G_clk);
      check($sformatf("bp_hold%0d", c), 64'({S_ARVALID, S_ARADDR[31:0]}), {30'd0, 2'b01, 32'h40});
    end
    ar_block[0] = 1'b0;
    got = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge G_clk);
      if (M_RVALID[0]) got = 1;
    end
    check("bp_beat0", 64'({got, M_RDATA[31:0]}), {31'd0, 1'b1, 32'h40});
    @(posedge G_clk); #1; M_RREADY[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge G_clk);
      check($sformatf("bp_stall_srready%0d", c), 64'(S_RREADY[0]), 64'd0);
      check($sformatf("bp_stall_data%0d", c), 64'({M_RVALID[0], M_RDATA[31:0]}), {31'd0, 1'b1, 32'h41});
    end
    @(posedge G_clk); #1; M_RREADY[0] = 1'b1;
    @(negedge G_clk);
    check("bp_resume", 64'({S_RREADY[0], M_RDATA[31:0]}), {31'd0, 1'b1, 32'h41});
    G_reset = 1'b0;
    #1;
    check("bp_reset_outs", 64'(any_out()), 64'd0);
    @(posedge G_clk); @(posedge G_clk); #1;
    G_reset = 1'b1;
    do_read(0, 32'h0000_0080, 4'd1, 0, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
